// File: rtl/julia_pkg.sv
// Shared types and fixed-point constants for the Julia/Mandelbrot escape-time engine.
package julia_pkg;

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

  localparam int FRAC_DEFAULT = 16;

  function automatic longint fx_one(input int frac);
    return longint'(1) << frac;
  endfunction

  function automatic longint fx_four(input int frac);
    return longint'(4) << frac;
  endfunction

  localparam longint FX_ONE  = fx_one(FRAC_DEFAULT);
  localparam longint FX_FOUR = fx_four(FRAC_DEFAULT);

  // Julia presets in Q16.16, rounded to nearest
  localparam logic signed [31:0] C1_X = -32'sd26214;
  localparam logic signed [31:0] C1_Y =  32'sd39322;
  localparam logic signed [31:0] C2_X = -32'sd52429;
  localparam logic signed [31:0] C2_Y =  32'sd10224;
  localparam logic signed [31:0] C3_X = -32'sd47638;
  localparam logic signed [31:0] C3_Y =  32'sd12380;

endpackage

// File: rtl/julia_fx_mul.sv
// Signed fixed-point multiply: full-width product, floor (arithmetic) shift by FRAC.
module julia_fx_mul #(
  parameter int W    = 32,
  parameter int FRAC = 16
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] p
);

  logic signed [2*W-1:0] prod;

  assign prod = a * b;
  assign p    = W'(prod >>> FRAC);

endmodule

// File: rtl/julia_iter_engine.sv
// Back-pressured, tagged escape-time iterator (Julia or Mandelbrot per point).
module julia_iter_engine
  import julia_pkg::*;
#(
  parameter int W        = 32,
  parameter int FRAC     = 16,
  parameter int ITER_W   = 9,
  parameter int MAX_ITER = 256,
  parameter int TAG_W    = 20
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] in_x,
  input  logic signed [W-1:0] in_y,
  input  logic [TAG_W-1:0]    in_tag,
  input  logic signed [W-1:0] c_x,
  input  logic signed [W-1:0] c_y,
  input  logic                mode,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ITER_W-1:0]   out_iter,
  output logic                out_escaped,
  output logic [TAG_W-1:0]    out_tag
);

  localparam logic signed [W:0]    MAG_LIMIT = (W+1)'(fx_four(FRAC));
  localparam logic [ITER_W-1:0]    ITER_CAP  = ITER_W'(MAX_ITER);

  state_t               state;
  logic signed [W-1:0]  zx, zy, cx, cy;
  logic [ITER_W-1:0]    iter;
  logic [TAG_W-1:0]     tag;

  logic signed [W-1:0]  sq_x, sq_y, xy;
  logic signed [W:0]    mag;
  logic signed [W-1:0]  zx_next, zy_next;
  logic                 accept;

  julia_fx_mul #(.W(W), .FRAC(FRAC)) u_mul_xx (.a(zx), .b(zx), .p(sq_x));
  julia_fx_mul #(.W(W), .FRAC(FRAC)) u_mul_yy (.a(zy), .b(zy), .p(sq_y));
  julia_fx_mul #(.W(W), .FRAC(FRAC)) u_mul_xy (.a(zx), .b(zy), .p(xy));

  // Iteration datapath: escape test and next z from the current z
  assign mag     = $signed({sq_x[W-1], sq_x}) + $signed({sq_y[W-1], sq_y});
  assign zx_next = sq_x - sq_y + cx;
  assign zy_next = (xy <<< 1) + cy;

  assign in_ready = (state == S_IDLE) || (state == S_DONE && out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      out_valid   <= 1'b0;
      out_iter    <= '0;
      out_escaped <= 1'b0;
      out_tag     <= '0;
      zx          <= '0;
      zy          <= '0;
      cx          <= '0;
      cy          <= '0;
      iter        <= '0;
      tag         <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (state == S_DONE && out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
          if (accept) begin
            tag   <= in_tag;
            iter  <= '0;
            state <= S_ITER;
            if (mode) begin
              zx <= '0;
              zy <= '0;
              cx <= in_x;
              cy <= in_y;
            end else begin
              zx <= in_x;
              zy <= in_y;
              cx <= c_x;
              cy <= c_y;
            end
          end
        end
        S_ITER: begin
          if (mag > MAG_LIMIT || iter == ITER_CAP) begin
            out_escaped <= (mag > MAG_LIMIT);
            out_iter    <= iter;
            out_tag     <= tag;
            out_valid   <= 1'b1;
            state       <= S_DONE;
          end else begin
            zx   <= zx_next;
            zy   <= zy_next;
            iter <= iter + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/julia_iter_engine.md
# julia_iter_engine

Parametrised Julia/Mandelbrot escape-time engine: accepts one complex start point per valid/ready handshake, iterates z ← z² + c in signed fixed point, returns the iteration count with the point's tag. It sits between the pixel-coordinate generator and the colour-map/frame-buffer writer. The engine replaces the free-running, self-restarting iterator with a back-pressured, tagged one that supports runtime-selectable mode and c.

## Interface
- W, 32: fixed-point word width (signed, two's complement); requires W − FRAC ≥ 4
- FRAC, 16: fractional bits
- ITER_W, 9: iteration counter width
- MAX_ITER, 256: iteration cap; must satisfy MAX_ITER < 2^ITER_W
- TAG_W, 20: pass-through tag width (pixel address)
---
- clk  in  1  clock; single clock domain
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  start point offered
- in_ready  out  1  engine can accept
- in_x, in_y  in  W  start point (Julia: z0; Mandelbrot: c)
- in_tag  in  TAG_W  opaque tag
- c_x, c_y  in  W  Julia constant (ignored in Mandelbrot mode)
- mode  in  1  0 = Julia, 1 = Mandelbrot
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts result
- out_iter  out  ITER_W  final iteration count, 0..MAX_ITER
- out_escaped  out  1  1 = |z|² exceeded 4.0; 0 = hit MAX_ITER
- out_tag  out  TAG_W  tag of the point

## Operation
- States: IDLE, ITER, DONE.
- in_ready = (state == IDLE) || (state == DONE && out_ready).
- Accept (in_valid && in_ready): latch tag, mode, iter ← 0. Julia: z ← (in_x, in_y), c ← (c_x, c_y). Mandelbrot: z ← 0, c ← (in_x, in_y). Go to ITER.
- c_x, c_y, mode are sampled only at accept. Changes mid-point have no effect on that point.
- ITER, each cycle: compute zx², zy², zx·zy from full 2W-bit products, arithmetic shift right by FRAC (floor), then:
  - mag = zx² + zy² in W+1 bits.
  - If mag > 4.0 (strict): set escaped ← 1, go to DONE.
  - Else if iter == MAX_ITER: set escaped ← 0, go to DONE.
  - Else: zx ← zx² − zy² + cx, zy ← (zx·zy << 1) + cy, iter ← iter + 1. Results truncate to W bits; the W − FRAC ≥ 4 constraint guarantees no wrap while |z| ≤ 2.
- DONE: out_valid = 1. out_iter, out_escaped, out_tag are registered and stable until out_ready.
  - out_ready && in_valid: accept the new point in the same cycle, go to ITER.
  - out_ready && !in_valid: go to IDLE.
- mag == 4.0 exactly does not escape.

## Timing
- Reset (rst_n low at a clk edge): state IDLE, out_valid 0, out_iter 0, out_escaped 0, out_tag 0, internal z/c/iter 0. in_ready is 1 from the first cycle after reset.
- Reset mid-ITER or mid-DONE aborts the point. No result is emitted.
- A point with final count n has out_valid high n + 2 cycles after the accept edge: 1 cycle for accept→ITER, n + 1 ITER cycles.
- Back-to-back throughput: no idle cycle between the out handshake and the next accept.
- out_valid never drops without out_ready. Outputs do not change while out_valid && !out_ready.

## Structure
- Shared package julia_pkg holds:
  - state enum
  - fixed-point helper constants FX_ONE, FX_FOUR (derived from FRAC)
  - Julia presets: C1 (−0.4, 0.6), C2 (−0.8, 0.156), C3 (−0.7269, 0.1889)
- One sub-module, julia_fx_mul, parametrised W/FRAC: signed multiply with floor shift. Instantiate three copies (zx², zy², zx·zy). The doubling is a shift, not a multiplier.

## Test plan
- Reset: hold rst_n low 2 cycles mid-ITER -> in_ready 1, out_valid 0, out_iter 0, out_tag 0; the aborted point produces no output.
- Julia, c = 0, z0 = (2.5, 0) -> out_iter 0, out_escaped 1, out_valid 2 cycles after accept. z0 = (2.0, 0) -> out_iter 1 (4.0 does not escape). z0 = (1.5, 0) -> out_iter 1.
- Julia, c = 0, z0 = (0, 0) -> out_iter 256, out_escaped 0, out_valid 258 cycles after accept.
- Mandelbrot, in = (1.0, 0) -> z sequence 0, 1, 2, 5 -> out_iter 3, out_escaped 1. Changing c_x mid-point does not change the result.
- Back-pressure: hold out_ready low 10 cycles -> out_* stable, in_ready 0. Raise out_ready with in_valid high -> next point accepted the same cycle with no bubble. Tags come out in input order.
- Julia with preset C1, random points -> out_iter matches the bit-accurate reference model (floor-shift fixed point) for 1000 points.
